// File: rtl/vr_scan_ctrl.sv
// ---------------------------------------------------------------------------
// vr_scan_ctrl
//
// Scan sequencer that time-multiplexes one potentiometer location detector
// across C_CH_N pots through an external analog mux. For each channel it
// drives the mux select, waits C_SETTLE enabled cycles for the detector LPF
// to converge, samples the 8-bit location, applies a hysteresis dead band
// against the last stored value for that channel and reports real changes as
// events over a valid/ready handshake.
//
// Parameters:
//   C_CH_N    number of pots scanned (>= 2)
//   C_SETTLE  settle time per channel in enabled cycles (>= 1)
//   C_HYST    dead band; a change is reported only when |new - stored| > C_HYST
//
// Ports:
//   CK_i      clock
//   XARST_i   asynchronous active-low reset
//   EN_CK_i   clock enable; gates every state advance except the event
//             handshake. Intended to default high (pulled up where it is
//             left unconnected at the instantiating level).
//   RUN_i     1 = scan continuously; dropping it finishes the current scan
//   SEL_o     analog mux channel select
//   LOC_i     location from the detector (0x01..0xFF, 0x80 = centre)
//   LOC_o     stored location per channel, channel k at [k*8 +: 8]
//   EV_VLD_o  change event valid
//   EV_RDY_i  change event accept
//   EV_CH_o   channel of the event
//   EV_LOC_o  location value of the event
//   BUSY_o    1 whenever the sequencer is not idle
//
// Build option:
//   VR_SCAN_AVG_EN  when defined, the sample phase averages 4 consecutive
//                   enabled-cycle readings of LOC_i (truncating) instead of
//                   taking a single reading.
// ---------------------------------------------------------------------------
module vr_scan_ctrl #(
  parameter int C_CH_N   = 4,
  parameter int C_SETTLE = 524288,
  parameter int C_HYST   = 2
) (
  input  logic                      CK_i,
  input  logic                      XARST_i,
  input  logic                      EN_CK_i,
  input  logic                      RUN_i,
  output logic [$clog2(C_CH_N)-1:0] SEL_o,
  input  logic [7:0]                LOC_i,
  output logic [C_CH_N*8-1:0]       LOC_o,
  output logic                      EV_VLD_o,
  input  logic                      EV_RDY_i,
  output logic [$clog2(C_CH_N)-1:0] EV_CH_o,
  output logic [7:0]                EV_LOC_o,
  output logic                      BUSY_o
);

  localparam int SW = $clog2(C_CH_N);
  // C_SETTLE-1 always fits in clog2(C_SETTLE) bits; keep at least one bit
  // so C_SETTLE=1 still builds.
  localparam int CW = (C_SETTLE > 1) ? $clog2(C_SETTLE) : 1;

  localparam logic [CW-1:0] SETTLE_LD = CW'(C_SETTLE - 1);
  localparam logic [SW-1:0] CH_LAST   = SW'(C_CH_N - 1);
  localparam logic [8:0]    HYST      = 9'(C_HYST);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_COMPARE,
    ST_EVENT,
    ST_NEXT
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [7:0]        smp_q;
  logic [7:0]        loc_q [C_CH_N];
  logic [C_CH_N-1:0] seen_q;

  logic              ch_last;
  logic              smp_done;
  logic [7:0]        smp_d;
  logic [8:0]        diff;
  logic [8:0]        diff_abs;
  logic              report;

  assign ch_last = (SEL_o == CH_LAST);

  // -------------------------------------------------------------------------
  // Sample source: single reading, or 4-reading truncating average.
  // -------------------------------------------------------------------------
`ifdef VR_SCAN_AVG_EN
  logic [1:0] avg_cnt_q;
  logic [9:0] acc_q;
  logic [9:0] acc_sum;

  assign acc_sum  = acc_q + {2'b00, LOC_i};
  assign smp_done = (avg_cnt_q == 2'd3);
  assign smp_d    = acc_sum[9:2];

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      avg_cnt_q <= '0;
      acc_q     <= '0;
    end else if (state_q == ST_SAMPLE && EN_CK_i) begin
      if (smp_done) begin
        // Clear on the way out so the next channel starts from zero.
        avg_cnt_q <= '0;
        acc_q     <= '0;
      end else begin
        avg_cnt_q <= avg_cnt_q + 2'd1;
        acc_q     <= acc_sum;
      end
    end
  end
`else
  assign smp_done = 1'b1;
  assign smp_d    = LOC_i;
`endif

  // -------------------------------------------------------------------------
  // Hysteresis: 9-bit signed difference so the full 8-bit span cannot wrap.
  // -------------------------------------------------------------------------
  assign diff     = {1'b0, smp_q} - {1'b0, loc_q[SEL_o]};
  assign diff_abs = diff[8] ? (~diff + 9'd1) : diff;
  assign report   = !seen_q[SEL_o] || (diff_abs > HYST);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: every clocked process uses non-blocking assignments so that all
  // registers update from the same pre-edge values, avoiding order races.
  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // -------------------------------------------------------------------------
  // Next-state logic. The event handshake is the only transition that does
  // not wait for EN_CK_i, so a downstream consumer is never throttled.
  // -------------------------------------------------------------------------
  // NOTE: state_d is given its hold value before the case so that no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (EN_CK_i && RUN_i)          state_d = ST_SETTLE;
      ST_SETTLE:  if (EN_CK_i && cnt_q == '0)    state_d = ST_SAMPLE;
      ST_SAMPLE:  if (EN_CK_i && smp_done)       state_d = ST_COMPARE;
      ST_COMPARE: if (EN_CK_i)                   state_d = report ? ST_EVENT : ST_NEXT;
      ST_EVENT:   if (EV_RDY_i && EV_VLD_o)      state_d = ST_NEXT;
      ST_NEXT:    if (EN_CK_i)                   state_d = (ch_last && !RUN_i) ? ST_IDLE : ST_SETTLE;
      default:                                   state_d = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      cnt_q    <= '0;
      SEL_o    <= '0;
      smp_q    <= '0;
      seen_q   <= '0;
      EV_VLD_o <= 1'b0;
      EV_CH_o  <= '0;
      EV_LOC_o <= 8'h80;
      // NOTE: the per-channel store is a small register file, not a RAM; it
      // must be reset because its centre value is architecturally visible
      // on LOC_o and feeds the hysteresis compare.
      for (int k = 0; k < C_CH_N; k++) loc_q[k] <= 8'h80;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (EN_CK_i && RUN_i) begin
            SEL_o <= '0;
            cnt_q <= SETTLE_LD;
          end
        end
        ST_SETTLE: begin
          if (EN_CK_i && cnt_q != '0) cnt_q <= cnt_q - CW'(1);
        end
        ST_SAMPLE: begin
          if (EN_CK_i && smp_done) smp_q <= smp_d;
        end
        ST_COMPARE: begin
          if (EN_CK_i && report) begin
            loc_q[SEL_o]  <= smp_q;
            seen_q[SEL_o] <= 1'b1;
            EV_CH_o       <= SEL_o;
            EV_LOC_o      <= smp_q;
            EV_VLD_o      <= 1'b1;
          end
        end
        ST_EVENT: begin
          if (EV_RDY_i && EV_VLD_o) EV_VLD_o <= 1'b0;
        end
        ST_NEXT: begin
          // The last channel with RUN_i low parks the select on C_CH_N-1.
          if (EN_CK_i && !(ch_last && !RUN_i)) begin
            SEL_o <= ch_last ? '0 : SEL_o + SW'(1);
            cnt_q <= SETTLE_LD;
          end
        end
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  always_comb begin
    LOC_o = '0;
    for (int k = 0; k < C_CH_N; k++) LOC_o[k*8 +: 8] = loc_q[k];
  end

  assign BUSY_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_vr_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vr_scan_ctrl
//
// Self-checking bench for vr_scan_ctrl with C_CH_N=4, C_SETTLE=8, C_HYST=2.
// The detector is modelled as a per-channel pot value array indexed by the
// mux select. A scan-level model predicts, for each full scan, which
// channels must report and with what value; a per-cycle compare process
// checks the event stream, the handshake rules and LOC_o against it.
// Directed literal expectations pin the timing and a few model values.
// ---------------------------------------------------------------------------
module tb_vr_scan_ctrl;

  localparam int CH_N   = 4;
  localparam int SETTLE = 8;
  localparam int HYST   = 2;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        en    = 1'b1;
  logic        run   = 1'b0;
  logic        rdy   = 1'b1;
  logic [1:0]  sel;
  logic [1:0]  ev_ch;
  logic [7:0]  loc_in;
  logic [7:0]  ev_loc;
  logic [31:0] loc_out;
  logic        ev_vld;
  logic        busy;

  logic [7:0]  pot [CH_N];
  bit          en_div = 1'b0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  // Analog mux + detector: location follows the selected pot.
  assign loc_in = pot[sel];

  vr_scan_ctrl #(
    .C_CH_N  (CH_N),
    .C_SETTLE(SETTLE),
    .C_HYST  (HYST)
  ) dut (
    .CK_i    (clk),
    .XARST_i (rst_n),
    .EN_CK_i (en),
    .RUN_i   (run),
    .SEL_o   (sel),
    .LOC_i   (loc_in),
    .LOC_o   (loc_out),
    .EV_VLD_o(ev_vld),
    .EV_RDY_i(rdy),
    .EV_CH_o (ev_ch),
    .EV_LOC_o(ev_loc),
    .BUSY_o  (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Clock enable: always high, or high one cycle in four.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      en = en_div ? (cyc % 4 == 0) : 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Checking
  // -------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Scan-level model
  // -------------------------------------------------------------------------
  typedef struct {
    logic [1:0] ch;
    logic [7:0] loc;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] pred_loc [CH_N];   // store as of the end of the predicted scan
  bit         pred_seen[CH_N];
  logic [7:0] mdl_loc  [CH_N];   // store as of the last accepted event

  function automatic void model_reset();
    exp_q.delete();
    for (int k = 0; k < CH_N; k++) begin
      pred_loc[k]  = 8'h80;
      pred_seen[k] = 1'b0;
      mdl_loc[k]   = 8'h80;
    end
  endfunction

  // One full pass over all channels with the current pot values.
  function automatic void predict_scan();
    for (int k = 0; k < CH_N; k++) begin
      int  d;
      ev_t e;
      d = int'(pot[k]) - int'(pred_loc[k]);
      if (d < 0) d = -d;
      if (!pred_seen[k] || d > HYST) begin
        e.ch  = 2'(k);
        e.loc = pot[k];
        exp_q.push_back(e);
        pred_loc[k]  = pot[k];
        pred_seen[k] = 1'b1;
      end
    end
  endfunction

  // -------------------------------------------------------------------------
  // Per-cycle compare process (samples on the falling edge)
  // -------------------------------------------------------------------------
  logic       prev_vld = 1'b0;
  logic       prev_rdy = 1'b0;
  logic [1:0] prev_ch  = '0;
  logic [1:0] prev_sel = '0;
  logic [7:0] prev_loc = '0;

  always @(negedge clk) begin
    logic [31:0] exp_loc;
    if (!rst_n) begin
      prev_vld <= 1'b0;
      prev_rdy <= 1'b0;
    end else begin
      for (int k = 0; k < CH_N; k++) exp_loc[k*8 +: 8] = mdl_loc[k];
      // The store is written together with the rise of valid.
      if (ev_vld && exp_q.size() > 0) exp_loc[int'(exp_q[0].ch)*8 +: 8] = exp_q[0].loc;
      check("loc_o", loc_out, exp_loc);

      if (prev_vld && !prev_rdy) begin
        check("ev_vld_hold", ev_vld, 1'b1);
        check("ev_ch_hold", ev_ch, prev_ch);
        check("ev_loc_hold", ev_loc, prev_loc);
        check("sel_hold", sel, prev_sel);
      end
      if (prev_vld && prev_rdy) check("ev_vld_drop", ev_vld, 1'b0);

      if (ev_vld) begin
        check("busy_in_event", busy, 1'b1);
        check("sel_eq_ev_ch", sel, ev_ch);
        if (exp_q.size() == 0) begin
          check("unexpected_event", ev_vld, 1'b0);
        end else begin
          check("ev_ch", ev_ch, exp_q[0].ch);
          check("ev_loc", ev_loc, exp_q[0].loc);
          if (rdy) begin
            mdl_loc[exp_q[0].ch] = exp_q[0].loc;
            void'(exp_q.pop_front());
          end
        end
      end

      prev_vld <= ev_vld;
      prev_rdy <= rdy;
      prev_ch  <= ev_ch;
      prev_loc <= ev_loc;
      prev_sel <= sel;
    end
  end

  // -------------------------------------------------------------------------
  // Bounded waits
  // -------------------------------------------------------------------------
  task automatic drv_sync();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sel(input logic [1:0] v, input int budget, input string name);
    int n = 0;
    while (sel !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sel !== v) check(name, sel, v);
  endtask

  task automatic wait_vld(input logic v, input int budget, input string name);
    int n = 0;
    while (ev_vld !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (ev_vld !== v) check(name, ev_vld, v);
  endtask

  task automatic wait_busy(input logic v, input int budget, input string name);
    int n = 0;
    while (busy !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy !== v) check(name, busy, v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

  // -------------------------------------------------------------------------
  // Directed stimulus
  // -------------------------------------------------------------------------
  initial begin
    int t0;
    for (int k = 0; k < CH_N; k++) pot[k] = 8'h40;
    model_reset();
    repeat (3) @(posedge clk);
    #1;

    // Reset values
    check("rst_sel", sel, 2'd0);
    check("rst_loc_o", loc_out, 32'h8080_8080);
    check("rst_ev_vld", ev_vld, 1'b0);
    check("rst_ev_ch", ev_ch, 2'd0);
    check("rst_ev_loc", ev_loc, 8'h80);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;

    // Test 1: first scan reports every channel, 12 cycles per channel.
    predict_scan();
    drv_sync();
    run = 1'b1;
    wait_busy(1'b1, 10, "t1_busy_rise_timeout");
    t0 = cyc;
    wait_vld(1'b1, 40, "t1_vld_timeout");
    check("t1_sample_latency", cyc - t0, 10);
    check("t1_first_ev_loc", ev_loc, 8'h40);
    wait_sel(2'd1, 40, "t1_sel1_timeout");
    check("t1_sel1_time", cyc - t0, 12);
    wait_sel(2'd2, 40, "t1_sel2_timeout");
    check("t1_sel2_time", cyc - t0, 24);
    wait_sel(2'd3, 40, "t1_sel3_timeout");
    check("t1_sel3_time", cyc - t0, 36);
    wait_sel(2'd0, 40, "t1_wrap_timeout");
    check("t1_wrap_time", cyc - t0, 48);
    check("t1_events_left", exp_q.size(), 0);
    check("t1_loc_o", loc_out, 32'h4040_4040);

    // Test 2: |D|=2 inside the dead band, |D|=3 reported.
    pot[1] = 8'h42;
    predict_scan();
    wait_sel(2'd3, 100, "t2a_sel3_timeout");
    wait_sel(2'd0, 100, "t2a_wrap_timeout");
    check("t2a_loc_o", loc_out, 32'h4040_4040);
    pot[1] = 8'h3D;
    predict_scan();
    wait_vld(1'b1, 100, "t2b_vld_timeout");
    check("t2b_ev_ch", ev_ch, 2'd1);
    check("t2b_ev_loc", ev_loc, 8'h3D);
    wait_sel(2'd3, 100, "t2b_sel3_timeout");
    wait_sel(2'd0, 100, "t2b_wrap_timeout");
    check("t2b_events_left", exp_q.size(), 0);
    check("t2b_loc_o", loc_out, 32'h4040_3D40);

    // Test 3: back-pressure holds the event and the select.
    pot[2] = 8'h90;
    predict_scan();
    drv_sync();
    rdy = 1'b0;
    wait_vld(1'b1, 100, "t3_vld_timeout");
    repeat (50) @(negedge clk);
    check("t3_vld_after_50", ev_vld, 1'b1);
    check("t3_ch_after_50", ev_ch, 2'd2);
    check("t3_loc_after_50", ev_loc, 8'h90);
    check("t3_sel_after_50", sel, 2'd2);
    drv_sync();
    rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t3_vld_fall", ev_vld, 1'b0);
    check("t3_sel_before_adv", sel, 2'd2);
    @(negedge clk);
    check("t3_sel_adv", sel, 2'd3);
    wait_sel(2'd0, 100, "t3_wrap_timeout");

    // Test 4: RUN_i dropped on channel 1 finishes the scan, parks on 3.
    pot[3] = 8'h10;
    predict_scan();
    wait_sel(2'd1, 100, "t4_sel1_timeout");
    t0 = cyc;
    drv_sync();
    run = 1'b0;
    wait_busy(1'b0, 100, "t4_idle_timeout");
    check("t4_idle_time", cyc - t0, 34);
    check("t4_sel_park", sel, 2'd3);
    check("t4_events_left", exp_q.size(), 0);
    check("t4_loc_o", loc_out, 32'h1090_3D40);
    repeat (30) @(negedge clk);
    check("t4_busy_held", busy, 1'b0);
    check("t4_sel_held", sel, 2'd3);

    // Test 5: enable one cycle in four stretches every phase by 4.
    en_div = 1'b1;
    pot[0] = 8'h50;
    predict_scan();
    drv_sync();
    run = 1'b1;
    wait_busy(1'b1, 20, "t5_busy_rise_timeout");
    t0 = cyc;
    wait_vld(1'b1, 100, "t5_vld_timeout");
    check("t5_sample_latency", cyc - t0, 40);
    check("t5_ev_loc", ev_loc, 8'h50);
    wait_sel(2'd1, 20, "t5_sel1_timeout");
    check("t5_sel1_time", cyc - t0, 44);
    drv_sync();
    run = 1'b0;
    wait_busy(1'b0, 400, "t5_idle_timeout");
    check("t5_events_left", exp_q.size(), 0);
    check("t5_loc_o", loc_out, 32'h1090_3D50);
    check("t5_sel_park", sel, 2'd3);
    en_div = 1'b0;

    // Test 6: asynchronous reset during a pending event.
    pot[0] = 8'h60;
    predict_scan();
    drv_sync();
    rdy = 1'b0;
    run = 1'b1;
    wait_vld(1'b1, 50, "t6_vld_timeout");
    repeat (3) @(negedge clk);
    drv_sync();
    rst_n = 1'b0;
    #1;
    check("t6_rst_ev_vld", ev_vld, 1'b0);
    check("t6_rst_loc_o", loc_out, 32'h8080_8080);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_sel", sel, 2'd0);
    check("t6_rst_ev_loc", ev_loc, 8'h80);
    model_reset();
    rdy = 1'b1;
    repeat (2) @(posedge clk);
    predict_scan();
    #1;
    rst_n = 1'b1;
    wait_vld(1'b1, 50, "t6_rereport_timeout");
    check("t6_rereport_ch", ev_ch, 2'd0);
    check("t6_rereport_loc", ev_loc, 8'h60);
    drv_sync();
    run = 1'b0;
    wait_busy(1'b0, 100, "t6_idle_timeout");
    check("t6_events_left", exp_q.size(), 0);
    check("t6_loc_o", loc_out, 32'h1090_3D60);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
